// File: rtl/crt_point_pacer_pkg.sv
// Shared types and defaults for the CRT point pacer: point word layout, read FSM states,
// and the saturating counter helper.
package crt_point_pacer_pkg;

   localparam int unsigned PointW   = 23;
   localparam int unsigned DefDepth = 16;
   localparam int unsigned DefGap   = 4;
   localparam int unsigned CountW   = 16;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic [2:0] br;
   } point_t;

   typedef enum logic [1:0] {
      StIdle,
      StEmit,
      StGap
   } state_t;

   function automatic logic [CountW-1:0] sat_inc(input logic [CountW-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/crt_point_pacer_if.sv
// Point source / CRT sink / debug bundle for crt_point_pacer. Signal names are seen from
// the pacer: i_* flow into it, o_* flow out of it.
interface crt_point_pacer_if
   import crt_point_pacer_pkg::*;
#(
   parameter int unsigned DEPTH = DefDepth
);
   localparam int unsigned LevelW = $clog2(DEPTH + 1);

   logic [9:0]        i_pixel_x;
   logic [9:0]        i_pixel_y;
   logic [2:0]        i_pixel_brightness;
   logic              i_pixel_valid;
   logic [9:0]        o_pixel_x;
   logic [9:0]        o_pixel_y;
   logic [2:0]        o_pixel_brightness;
   logic              o_pixel_valid;
   logic [LevelW-1:0] o_dbg_level;
   logic [CountW-1:0] o_dbg_drop_count;
   logic [CountW-1:0] o_dbg_dup_count;
   logic              o_dbg_overflow;

   modport master (
      output i_pixel_x, i_pixel_y, i_pixel_brightness, i_pixel_valid,
      input  o_pixel_x, o_pixel_y, o_pixel_brightness, o_pixel_valid,
      input  o_dbg_level, o_dbg_drop_count, o_dbg_dup_count, o_dbg_overflow
   );

   modport slave (
      input  i_pixel_x, i_pixel_y, i_pixel_brightness, i_pixel_valid,
      output o_pixel_x, o_pixel_y, o_pixel_brightness, o_pixel_valid,
      output o_dbg_level, o_dbg_drop_count, o_dbg_dup_count, o_dbg_overflow
   );

endinterface

// File: rtl/crt_point_fifo.sv
// DEPTH x WIDTH synchronous FIFO with flush; push while full is legal when popping in the
// same cycle. Head is read straight from the storage flops.
module crt_point_fifo
   import crt_point_pacer_pkg::*;
#(
   parameter int unsigned DEPTH = DefDepth,
   parameter int unsigned WIDTH = PointW
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_flush,
   input  logic                         i_push,
   input  logic                         i_pop,
   input  logic [WIDTH-1:0]             i_data,
   output logic [WIDTH-1:0]             o_head,
   output logic [$clog2(DEPTH+1)-1:0]   o_level,
   output logic                         o_empty,
   output logic                         o_full
);
   localparam int unsigned PtrW   = $clog2(DEPTH);
   localparam int unsigned LevelW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0]  mem [DEPTH];
   logic [PtrW-1:0]   wr_q;
   logic [PtrW-1:0]   rd_q;
   logic [LevelW-1:0] level_q;

   always_ff @(posedge i_clk) begin
      if (i_push) begin
         mem[wr_q] <= i_data;
      end
   end

   // DEPTH is a power of two, so pointer increments wrap naturally.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_flush) begin
         wr_q    <= '0;
         rd_q    <= '0;
         level_q <= '0;
      end else begin
         if (i_push) wr_q <= wr_q + 1'b1;
         if (i_pop)  rd_q <= rd_q + 1'b1;
         level_q <= level_q + LevelW'(i_push) - LevelW'(i_pop);
      end
   end

   assign o_head  = mem[rd_q];
   assign o_level = level_q;
   assign o_empty = (level_q == '0);
   assign o_full  = (level_q == LevelW'(DEPTH));

endmodule

// File: rtl/crt_point_pacer.sv
// Point queue between a point source and the CRT: drops duplicates, buffers bursts and
// re-emits points no faster than one strobe per GAP_CYCLES clocks.
module crt_point_pacer
   import crt_point_pacer_pkg::*;
#(
   parameter int unsigned DEPTH        = DefDepth,
   parameter int unsigned GAP_CYCLES   = DefGap,
   parameter bit          SUPPRESS_DUP = 1'b1
) (
   input  logic           i_clk,
   input  logic           i_rst,
   input  logic           i_flush,
   crt_point_pacer_if.slave pix
);
   localparam int unsigned LevelW  = $clog2(DEPTH + 1);
   localparam logic [15:0] GapLoad = (GAP_CYCLES > 1) ? 16'(GAP_CYCLES - 2) : 16'd0;

   point_t            in_pt;
   point_t            head_pt;
   point_t            last_q;
   point_t            out_q;
   logic              dup_valid_q;
   state_t            state_q;
   state_t            state_d;
   logic [15:0]       gap_q;
   logic [15:0]       gap_d;
   logic              valid_q;
   logic [CountW-1:0] drop_cnt_q;
   logic [CountW-1:0] dup_cnt_q;
   logic              overflow_q;
   logic              fifo_empty;
   logic              fifo_full;
   logic [LevelW-1:0] level;
   logic              is_dup;
   logic              pop;
   logic              push;
   logic              drop;
   logic              dup_hit;

   assign in_pt = point_t'{x: pix.i_pixel_x, y: pix.i_pixel_y, br: pix.i_pixel_brightness};

   assign is_dup  = SUPPRESS_DUP && dup_valid_q && (in_pt == last_q);
   assign dup_hit = pix.i_pixel_valid && !i_flush && is_dup;
   assign push    = pix.i_pixel_valid && !i_flush && !is_dup && (!fifo_full || pop);
   assign drop    = pix.i_pixel_valid && !i_flush && !is_dup && fifo_full && !pop;

   crt_point_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (PointW)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_flush (i_flush),
      .i_push  (push),
      .i_pop   (pop),
      .i_data  (in_pt),
      .o_head  (head_pt),
      .o_level (level),
      .o_empty (fifo_empty),
      .o_full  (fifo_full)
   );

   // The head is popped into the output register on the cycle that enters EMIT, so the
   // registered strobe lines up with the EMIT state and the final GAP cycle can chain
   // straight into the next EMIT for exact GAP_CYCLES spacing.
   always_comb begin
      state_d = state_q;
      gap_d   = gap_q;
      pop     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!fifo_empty) begin
               state_d = StEmit;
               pop     = 1'b1;
            end
         end
         StEmit: begin
            if (GAP_CYCLES == 1) begin
               if (fifo_empty) state_d = StIdle;
               else            pop     = 1'b1;
            end else begin
               state_d = StGap;
               gap_d   = GapLoad;
            end
         end
         StGap: begin
            if (gap_q == '0) begin
               if (fifo_empty) begin
                  state_d = StIdle;
               end else begin
                  state_d = StEmit;
                  pop     = 1'b1;
               end
            end else begin
               gap_d = gap_q - 16'd1;
            end
         end
         default: state_d = StIdle;
      endcase
      if (i_flush) begin
         state_d = StIdle;
         pop     = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= StIdle;
         gap_q       <= '0;
         valid_q     <= 1'b0;
         out_q       <= '0;
         last_q      <= '0;
         dup_valid_q <= 1'b0;
         drop_cnt_q  <= '0;
         dup_cnt_q   <= '0;
         overflow_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         gap_q   <= gap_d;
         valid_q <= pop;
         if (pop) out_q <= head_pt;
         if (i_flush) begin
            dup_valid_q <= 1'b0;
         end else if (push) begin
            last_q      <= in_pt;
            dup_valid_q <= 1'b1;
         end
         if (drop) begin
            drop_cnt_q <= sat_inc(drop_cnt_q);
            overflow_q <= 1'b1;
         end
         if (dup_hit) dup_cnt_q <= sat_inc(dup_cnt_q);
      end
   end

   assign pix.o_pixel_x          = out_q.x;
   assign pix.o_pixel_y          = out_q.y;
   assign pix.o_pixel_brightness = out_q.br;
   assign pix.o_pixel_valid      = valid_q;
   assign pix.o_dbg_level        = level;
   assign pix.o_dbg_drop_count   = drop_cnt_q;
   assign pix.o_dbg_dup_count    = dup_cnt_q;
   assign pix.o_dbg_overflow     = overflow_q;

endmodule

// File: tb/tb_crt_point_pacer.sv
// Scoreboard bench for crt_point_pacer: one instance with GAP_CYCLES=4, one with GAP_CYCLES=1.
module tb_crt_point_pacer;
   import crt_point_pacer_pkg::*;

   localparam int unsigned DEPTH = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a, rst_b, flush_a, flush_b;
   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   crt_point_pacer_if #(.DEPTH(DEPTH)) pa ();
   crt_point_pacer_if #(.DEPTH(DEPTH)) pb ();

   crt_point_pacer #(.DEPTH(DEPTH), .GAP_CYCLES(4), .SUPPRESS_DUP(1'b1)) u_dut_a (
      .i_clk   (clk),
      .i_rst   (rst_a),
      .i_flush (flush_a),
      .pix     (pa)
   );

   crt_point_pacer #(.DEPTH(DEPTH), .GAP_CYCLES(1), .SUPPRESS_DUP(1'b1)) u_dut_b (
      .i_clk   (clk),
      .i_rst   (rst_b),
      .i_flush (flush_b),
      .pix     (pb)
   );

   int compared = 0;
   int mismatched = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // Scoreboard state
   point_t exp_a[$];
   point_t exp_b[$];
   int     sa[$];
   int     sb[$];
   bit     relaxed_a = 1'b0;
   int     last_idx;
   int     n_relaxed;
   point_t ea, eb;

   always @(negedge clk) begin
      if (pa.o_pixel_valid === 1'b1) begin
         sa.push_back(cyc);
         if (relaxed_a) begin
            // Overflow run: emitted points must be an increasing subsequence of 0..39.
            chk("t3_order", {31'd0, (int'(pa.o_pixel_x) > last_idx) && (pa.o_pixel_x < 10'd40)},
                32'd1);
            last_idx = int'(pa.o_pixel_x);
            n_relaxed++;
         end else if (exp_a.size() == 0) begin
            chk("a_unexpected_strobe", {9'd0, pa.o_pixel_x, pa.o_pixel_y, pa.o_pixel_brightness},
                32'hFFFF_FFFF);
         end else begin
            ea = exp_a.pop_front();
            chk("a_point", {9'd0, pa.o_pixel_x, pa.o_pixel_y, pa.o_pixel_brightness}, {9'd0, ea});
         end
      end
      if (pb.o_pixel_valid === 1'b1) begin
         sb.push_back(cyc);
         if (exp_b.size() == 0) begin
            chk("b_unexpected_strobe", {9'd0, pb.o_pixel_x, pb.o_pixel_y, pb.o_pixel_brightness},
                32'hFFFF_FFFF);
         end else begin
            eb = exp_b.pop_front();
            chk("b_point", {9'd0, pb.o_pixel_x, pb.o_pixel_y, pb.o_pixel_brightness}, {9'd0, eb});
         end
      end
   end

   task automatic put_a(input logic [9:0] x, input logic [9:0] y, input logic [2:0] b,
                        input bit expect_out);
      pa.i_pixel_x = x; pa.i_pixel_y = y; pa.i_pixel_brightness = b; pa.i_pixel_valid = 1'b1;
      if (expect_out) exp_a.push_back(point_t'{x: x, y: y, br: b});
      @(negedge clk);
   endtask

   task automatic put_b(input logic [9:0] x, input logic [9:0] y, input logic [2:0] b,
                        input bit expect_out);
      pb.i_pixel_x = x; pb.i_pixel_y = y; pb.i_pixel_brightness = b; pb.i_pixel_valid = 1'b1;
      if (expect_out) exp_b.push_back(point_t'{x: x, y: y, br: b});
      @(negedge clk);
   endtask

   task automatic idle_a(input int n);
      pa.i_pixel_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic idle_b(input int n);
      pb.i_pixel_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   int t0, n0, d0, r0;

   initial begin
      rst_a = 1'b1; rst_b = 1'b1; flush_a = 1'b0; flush_b = 1'b0;
      pa.i_pixel_x = '0; pa.i_pixel_y = '0; pa.i_pixel_brightness = '0; pa.i_pixel_valid = 1'b0;
      pb.i_pixel_x = '0; pb.i_pixel_y = '0; pb.i_pixel_brightness = '0; pb.i_pixel_valid = 1'b0;
      repeat (3) @(negedge clk);

      chk("rst_valid", {31'd0, pa.o_pixel_valid}, 32'd0);
      chk("rst_point", {9'd0, pa.o_pixel_x, pa.o_pixel_y, pa.o_pixel_brightness}, 32'd0);
      chk("rst_level", 32'(pa.o_dbg_level), 32'd0);
      chk("rst_drop", {16'd0, pa.o_dbg_drop_count}, 32'd0);
      chk("rst_dup", {16'd0, pa.o_dbg_dup_count}, 32'd0);
      chk("rst_overflow", {31'd0, pa.o_dbg_overflow}, 32'd0);
      rst_a = 1'b0; rst_b = 1'b0;
      @(negedge clk);

      // 1: single point, two-cycle latency
      t0 = cyc; n0 = sa.size();
      put_a(10'd100, 10'd200, 3'd7, 1'b1);
      idle_a(8);
      chk("t1_strobes", 32'(sa.size() - n0), 32'd1);
      if (sa.size() > n0) chk("t1_latency", 32'(sa[n0] - t0), 32'd2);
      chk("t1_level", 32'(pa.o_dbg_level), 32'd0);

      // 2: burst of 8, strobes exactly 4 apart
      t0 = cyc; n0 = sa.size();
      for (int i = 0; i < 8; i++) put_a(10'(10 + i), 10'(20 + i), 3'(i), 1'b1);
      idle_a(40);
      chk("t2_strobes", 32'(sa.size() - n0), 32'd8);
      if (sa.size() > n0) chk("t2_latency", 32'(sa[n0] - t0), 32'd2);
      for (int i = 1; i < 8; i++) begin
         if (sa.size() > n0 + i) chk("t2_spacing", 32'(sa[n0 + i] - sa[n0 + i - 1]), 32'd4);
      end
      chk("t2_drop", {16'd0, pa.o_dbg_drop_count}, 32'd0);
      chk("t2_drained", 32'(exp_a.size()), 32'd0);

      // 3: 40 back-to-back points overflow the 16-deep queue
      relaxed_a = 1'b1; last_idx = -1; n_relaxed = 0;
      for (int i = 0; i < 40; i++) put_a(10'(i), 10'(i + 512), 3'(i), 1'b0);
      idle_a(160);
      relaxed_a = 1'b0;
      chk("t3_total", 32'(n_relaxed) + {16'd0, pa.o_dbg_drop_count}, 32'd40);
      chk("t3_dropped", {31'd0, pa.o_dbg_drop_count != 16'd0}, 32'd1);
      chk("t3_overflow", {31'd0, pa.o_dbg_overflow}, 32'd1);
      chk("t3_level", 32'(pa.o_dbg_level), 32'd0);
      r0 = int'(pa.o_dbg_drop_count);

      // 4: duplicates suppressed
      d0 = int'(pa.o_dbg_dup_count); n0 = sa.size();
      put_a(10'd5, 10'd5, 3'd3, 1'b1);
      put_a(10'd5, 10'd5, 3'd3, 1'b0);
      put_a(10'd5, 10'd5, 3'd3, 1'b0);
      put_a(10'd6, 10'd5, 3'd3, 1'b1);
      idle_a(20);
      chk("t4_dup", 32'(int'(pa.o_dbg_dup_count) - d0), 32'd2);
      chk("t4_strobes", 32'(sa.size() - n0), 32'd2);

      // 5: flush mid-GAP after the third strobe; a duplicate offered during flush is ignored
      n0 = sa.size(); d0 = int'(pa.o_dbg_dup_count);
      for (int i = 0; i < 10; i++) put_a(10'(50 + i), 10'(60 + i), 3'd1, i < 3);
      idle_a(2);
      flush_a = 1'b1;
      put_a(10'd59, 10'd69, 3'd1, 1'b0);
      flush_a = 1'b0;
      idle_a(30);
      chk("t5_strobes", 32'(sa.size() - n0), 32'd3);
      chk("t5_level", 32'(pa.o_dbg_level), 32'd0);
      chk("t5_dup", 32'(int'(pa.o_dbg_dup_count) - d0), 32'd0);
      chk("t5_drop", 32'(int'(pa.o_dbg_drop_count) - r0), 32'd0);
      chk("t5_overflow", {31'd0, pa.o_dbg_overflow}, 32'd1);
      put_a(10'd59, 10'd69, 3'd1, 1'b1);
      idle_a(10);
      chk("t5_reaccept", 32'(sa.size() - n0), 32'd4);
      chk("t5_drained", 32'(exp_a.size()), 32'd0);

      // 6: GAP=1 instance strobes every cycle; then reset during the second strobe
      t0 = cyc; n0 = sb.size();
      for (int i = 0; i < 4; i++) put_b(10'(200 + i), 10'(300 + i), 3'd5, 1'b1);
      idle_b(10);
      chk("t6_strobes", 32'(sb.size() - n0), 32'd4);
      if (sb.size() > n0) chk("t6_latency", 32'(sb[n0] - t0), 32'd2);
      for (int i = 1; i < 4; i++) begin
         if (sb.size() > n0 + i) chk("t6_spacing", 32'(sb[n0 + i] - sb[n0 + i - 1]), 32'd1);
      end

      n0 = sb.size();
      put_b(10'd400, 10'd500, 3'd2, 1'b1);
      put_b(10'd401, 10'd501, 3'd2, 1'b1);
      put_b(10'd402, 10'd502, 3'd2, 1'b0);
      rst_b = 1'b1;
      put_b(10'd403, 10'd503, 3'd2, 1'b0);
      rst_b = 1'b0;
      chk("t6_rst_valid", {31'd0, pb.o_pixel_valid}, 32'd0);
      chk("t6_rst_point", {9'd0, pb.o_pixel_x, pb.o_pixel_y, pb.o_pixel_brightness}, 32'd0);
      chk("t6_rst_level", 32'(pb.o_dbg_level), 32'd0);
      idle_b(10);
      chk("t6_rst_strobes", 32'(sb.size() - n0), 32'd2);
      chk("t6_drained", 32'(exp_b.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
